// File: rtl/bcd_conv_sched_if.sv
// Bundle of the requester, converter and response signals of bcd_conv_sched.
//
// master: the environment side (requesters + BCD converter) drives requests
//         and converter results, observes accepts, converter commands and
//         responses.
// slave : the scheduler side (bcd_conv_sched).
//
// Signals:
//   req_valid  [NUM_REQ]         per-requester request, held until accepted
//   req_data   [NUM_REQ*DATA_W]  operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_REQ]         one-hot accept strobe (IDLE only)
//   conv_start                   one-cycle start pulse to the converter
//   conv_data  [DATA_W]          clamped operand for the converter
//   conv_done                    converter result-valid pulse
//   conv_bcd   [BCD_W]           converter result
//   rsp_valid  [NUM_REQ]         one-hot, one-cycle response strobe
//   rsp_bcd    [BCD_W]           result, held between responses
//   rsp_ovf                      operand was clamped (qualified by rsp_valid)
//   rsp_err                      converter timed out (qualified by rsp_valid)
//   busy                         scheduler is not idle
interface bcd_conv_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BCD_W   = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      conv_start;
  logic [DATA_W-1:0]         conv_data;
  logic                      conv_done;
  logic [BCD_W-1:0]          conv_bcd;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [BCD_W-1:0]          rsp_bcd;
  logic                      rsp_ovf;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req_valid, req_data, conv_done, conv_bcd,
    input  req_ready, conv_start, conv_data, rsp_valid, rsp_bcd,
           rsp_ovf, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_data, conv_done, conv_bcd,
    output req_ready, conv_start, conv_data, rsp_valid, rsp_bcd,
           rsp_ovf, rsp_err, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shares one binary-to-8-digit-BCD converter among NUM_REQ requesters
// (frequency, Vpp, period, trigger-level readouts, ...).
//
// Flow: IDLE picks a requester round-robin and accepts it combinationally,
// START pulses conv_start with the clamped operand, WAIT holds until
// conv_done or TIMEOUT cycles, RESP returns the result to the owner.
// One conversion is in flight at a time.
//
// Ports:
//   sys_clk  system clock
//   sys_rst  synchronous active-high reset; abandons any in-flight job
//   bus      bcd_conv_sched_if.slave (requests, converter, responses)
module bcd_conv_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BCD_W   = 32,
  parameter int unsigned MAX_VAL = 99999999,
  parameter int unsigned TIMEOUT = 127
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  bcd_conv_sched_if.slave bus
);

  localparam int unsigned       IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MAX_V    = DATA_W'(MAX_VAL);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               conv_start_q, conv_start_d;
  logic [DATA_W-1:0]  conv_data_q, conv_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [BCD_W-1:0]   rsp_bcd_q, rsp_bcd_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [DATA_W-1:0]  operand;
  logic [NUM_REQ-1:0] req_ready_c;

  // Round-robin search starting at rr_ptr and wrapping; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    operand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        operand = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The accept strobe is combinational so the handshake completes in the
  // same cycle the winner is chosen.
  always_comb begin
    req_ready_c = '0;
    if (state_q == IDLE && win_found) begin
      req_ready_c[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    conv_start_d = 1'b0;
    conv_data_d  = conv_data_q;
    rsp_valid_d  = '0;
    rsp_bcd_d    = rsp_bcd_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          if (operand > MAX_V) begin
            conv_data_d = MAX_V;
            ovf_d       = 1'b1;
          end else begin
            conv_data_d = operand;
            ovf_d       = 1'b0;
          end
          // conv_start is registered, so it is raised on entry to START.
          conv_start_d = 1'b1;
          state_d      = START;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q counts completed WAIT cycles, so CNT_LAST marks the
        // TIMEOUT-th WAIT cycle; done takes priority over the timeout.
        if (bus.conv_done) begin
          rsp_bcd_d            = bus.conv_bcd;
          rsp_err_d            = 1'b0;
          rsp_ovf_d            = ovf_q;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_bcd_d            = '0;
          rsp_err_d            = 1'b1;
          rsp_ovf_d            = ovf_q;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end
      end

      RESP: begin
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      conv_start_q <= 1'b0;
      conv_data_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_bcd_q    <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      conv_start_q <= conv_start_d;
      conv_data_q  <= conv_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_bcd_q    <= rsp_bcd_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.conv_start = conv_start_q;
  assign bus.conv_data  = conv_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_bcd    = rsp_bcd_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched with a behavioural converter whose
// done latency is programmable (0 = never answers).
module tb_bcd_conv_sched;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BCD_W   = 32;
  localparam int unsigned TIMEOUT = 127;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int          model_lat = 0;
  int          rem       = 0;
  logic [31:0] cap;

  bcd_conv_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BCD_W(BCD_W)) bus ();

  bcd_conv_sched #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .BCD_W  (BCD_W),
    .MAX_VAL(99999999),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bin2bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Converter model: done pulses model_lat cycles after the start cycle.
  // conv_bcd carries junk except in the done cycle.
  initial begin
    bus.conv_done = 1'b0;
    bus.conv_bcd  = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #2;
      bus.conv_done = 1'b0;
      bus.conv_bcd  = 32'hDEADBEEF;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          bus.conv_done = 1'b1;
          bus.conv_bcd  = bin2bcd(cap);
        end
      end
      if (bus.conv_start === 1'b1 && model_lat != 0) begin
        rem = model_lat;
        cap = bus.conv_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [31:0] v);
    bus.req_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic wait_ready(input int budget, output int n);
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (bus.rsp_valid == '0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    tick();
    tick();
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    total++; if (bus.conv_start !== 1'b0) begin bad++; $display("FAIL reset_conv_start: got %b want 0", bus.conv_start); end
    total++; if (bus.conv_data !== 32'h0) begin bad++; $display("FAIL reset_conv_data: got %h want 0", bus.conv_data); end
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 32'h0) begin bad++; $display("FAIL reset_rsp_bcd: got %h want 0", bus.rsp_bcd); end
    total++; if (bus.rsp_ovf !== 1'b0) begin bad++; $display("FAIL reset_rsp_ovf: got %b want 0", bus.rsp_ovf); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    model_lat = 54;
    set_req(2, 32'd12345678);
    bus.req_valid = 4'b0100;
    wait_ready(4, n);
    total++; if (n !== 0) begin bad++; $display("FAIL single_ready_delay: got %0d want 0", n); end
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    total++; if (bus.conv_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", bus.conv_start); end
    total++; if (bus.conv_data !== 32'd12345678) begin bad++; $display("FAIL single_conv_data: got %0d want 12345678", bus.conv_data); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_after: got %b want 0000", bus.req_ready); end
    tick();
    total++; if (bus.conv_start !== 1'b0) begin bad++; $display("FAIL single_start_pulse: got %b want 0", bus.conv_start); end
    total++; if (bus.conv_data !== 32'd12345678) begin bad++; $display("FAIL single_conv_data_hold: got %0d want 12345678", bus.conv_data); end
    wait_rsp(100, n);
    total++; if (n !== 54) begin bad++; $display("FAIL single_latency: got %0d want 54", n); end
    total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL single_rsp_valid: got %b want 0100", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 32'h12345678) begin bad++; $display("FAIL single_rsp_bcd: got %h want 12345678", bus.rsp_bcd); end
    total++; if (bus.rsp_ovf !== 1'b0) begin bad++; $display("FAIL single_rsp_ovf: got %b want 0", bus.rsp_ovf); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp_err: got %b want 0", bus.rsp_err); end
    tick();
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_rsp_pulse: got %b want 0000", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
    total++; if (bus.rsp_bcd !== 32'h12345678) begin bad++; $display("FAIL single_rsp_bcd_hold: got %h want 12345678", bus.rsp_bcd); end
  endtask

  task automatic test_round_robin();
    int          n;
    int          order[6] = '{0, 1, 2, 3, 0, 3};
    logic [31:0] vals[4]  = '{32'd10, 32'd200, 32'd3000, 32'd40000};
    logic [31:0] bcds[4]  = '{32'h10, 32'h200, 32'h3000, 32'h40000};
    logic [3:0]  oh;
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    model_lat = 1;
    for (int i = 0; i < 4; i++) set_req(i, vals[i]);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      oh = 4'b0001 << order[k];
      wait_ready(8, n);
      total++; if (n !== ((k == 0) ? 0 : 1)) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want %0d", k, n, (k == 0) ? 0 : 1); end
      total++; if (bus.req_ready !== oh) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready, oh); end
      if (k == 3) bus.req_valid = 4'b1001;
      tick();
      if (k == 5) bus.req_valid = '0;
      total++; if (bus.conv_data !== vals[order[k]]) begin bad++; $display("FAIL rr_conv_data[%0d]: got %0d want %0d", k, bus.conv_data, vals[order[k]]); end
      wait_rsp(8, n);
      total++; if (n !== 2) begin bad++; $display("FAIL rr_latency[%0d]: got %0d want 2", k, n); end
      total++; if (bus.rsp_valid !== oh) begin bad++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", k, bus.rsp_valid, oh); end
      total++; if (bus.rsp_bcd !== bcds[order[k]]) begin bad++; $display("FAIL rr_rsp_bcd[%0d]: got %h want %h", k, bus.rsp_bcd, bcds[order[k]]); end
    end
  endtask

  task automatic test_clamp();
    int          n;
    logic [31:0] din[4]  = '{32'h05F5E100, 32'd99999999, 32'hFFFFFFFF, 32'd99999998};
    logic [31:0] dexp[4] = '{32'd99999999, 32'd99999999, 32'd99999999, 32'd99999998};
    logic        oexp[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] bexp[4] = '{32'h99999999, 32'h99999999, 32'h99999999, 32'h99999998};
    model_lat = 3;
    for (int v = 0; v < 4; v++) begin
      set_req(1, din[v]);
      bus.req_valid = 4'b0010;
      wait_ready(8, n);
      total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL clamp_ready[%0d]: got %b want 0010", v, bus.req_ready); end
      tick();
      bus.req_valid = '0;
      total++; if (bus.conv_data !== dexp[v]) begin bad++; $display("FAIL clamp_conv_data[%0d]: got %0d want %0d", v, bus.conv_data, dexp[v]); end
      wait_rsp(10, n);
      total++; if (n !== 4) begin bad++; $display("FAIL clamp_latency[%0d]: got %0d want 4", v, n); end
      total++; if (bus.rsp_valid !== 4'b0010) begin bad++; $display("FAIL clamp_rsp_valid[%0d]: got %b want 0010", v, bus.rsp_valid); end
      total++; if (bus.rsp_ovf !== oexp[v]) begin bad++; $display("FAIL clamp_ovf[%0d]: got %b want %b", v, bus.rsp_ovf, oexp[v]); end
      total++; if (bus.rsp_bcd !== bexp[v]) begin bad++; $display("FAIL clamp_bcd[%0d]: got %h want %h", v, bus.rsp_bcd, bexp[v]); end
    end
  endtask

  task automatic test_timeout();
    int n;
    model_lat = 0;
    set_req(2, 32'd77);
    bus.req_valid = 4'b0100;
    wait_ready(8, n);
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL to_ready: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    total++; if (bus.conv_start !== 1'b1) begin bad++; $display("FAIL to_start: got %b want 1", bus.conv_start); end
    tick();
    wait_rsp(TIMEOUT + 10, n);
    total++; if (n !== TIMEOUT) begin bad++; $display("FAIL to_latency: got %0d want %0d", n, TIMEOUT); end
    total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL to_rsp_valid: got %b want 0100", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", bus.rsp_err); end
    total++; if (bus.rsp_bcd !== 32'h0) begin bad++; $display("FAIL to_bcd: got %h want 0", bus.rsp_bcd); end
    total++; if (bus.rsp_ovf !== 1'b0) begin bad++; $display("FAIL to_ovf: got %b want 0", bus.rsp_ovf); end
    model_lat = 1;
    set_req(0, 32'd42);
    set_req(2, 32'd55);
    bus.req_valid = 4'b0101;
    wait_ready(8, n);
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL to_next_ready: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    wait_rsp(8, n);
    total++; if (n !== 2) begin bad++; $display("FAIL to_next_latency: got %0d want 2", n); end
    total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL to_next_rsp_valid: got %b want 0001", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 32'h42) begin bad++; $display("FAIL to_next_bcd: got %h want 00000042", bus.rsp_bcd); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL to_next_err: got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_done_timeout();
    int          n;
    int          lat[2]  = '{128, 127};
    logic        eerr[2] = '{1'b1, 1'b0};
    logic [31:0] ebcd[2] = '{32'h0, 32'h87654321};
    for (int c = 0; c < 2; c++) begin
      model_lat = lat[c];
      set_req(1, 32'd87654321);
      bus.req_valid = 4'b0010;
      wait_ready(8, n);
      total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL dt_ready[%0d]: got %b want 0010", c, bus.req_ready); end
      tick();
      bus.req_valid = '0;
      wait_rsp(TIMEOUT + 10, n);
      total++; if (n !== 128) begin bad++; $display("FAIL dt_latency[%0d]: got %0d want 128", c, n); end
      total++; if (bus.rsp_valid !== 4'b0010) begin bad++; $display("FAIL dt_rsp_valid[%0d]: got %b want 0010", c, bus.rsp_valid); end
      total++; if (bus.rsp_err !== eerr[c]) begin bad++; $display("FAIL dt_err[%0d]: got %b want %b", c, bus.rsp_err, eerr[c]); end
      total++; if (bus.rsp_bcd !== ebcd[c]) begin bad++; $display("FAIL dt_bcd[%0d]: got %h want %h", c, bus.rsp_bcd, ebcd[c]); end
      tick();
      total++; if (bus.rsp_bcd !== ebcd[c]) begin bad++; $display("FAIL dt_bcd_hold[%0d]: got %h want %h", c, bus.rsp_bcd, ebcd[c]); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL dt_busy[%0d]: got %b want 0", c, bus.busy); end
    end
  endtask

  task automatic test_reset_wait();
    int n;
    int rsp_seen  = 0;
    int busy_seen = 0;
    model_lat = 54;
    set_req(3, 32'd5);
    bus.req_valid = 4'b1000;
    wait_ready(8, n);
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL rw_ready: got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.conv_start !== 1'b0) begin bad++; $display("FAIL rw_conv_start: got %b want 0", bus.conv_start); end
    total++; if (bus.conv_data !== 32'h0) begin bad++; $display("FAIL rw_conv_data: got %h want 0", bus.conv_data); end
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL rw_rsp_valid: got %b want 0000", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 32'h0) begin bad++; $display("FAIL rw_rsp_bcd: got %h want 0", bus.rsp_bcd); end
    total++; if (bus.rsp_ovf !== 1'b0) begin bad++; $display("FAIL rw_rsp_ovf: got %b want 0", bus.rsp_ovf); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rw_rsp_err: got %b want 0", bus.rsp_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rw_busy: got %b want 0", bus.busy); end
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.rsp_valid !== 4'b0000) rsp_seen++;
      if (bus.busy !== 1'b0) busy_seen++;
    end
    total++; if (rsp_seen !== 0) begin bad++; $display("FAIL rw_late_rsp: got %0d strobes want 0", rsp_seen); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL rw_late_busy: got %0d busy cycles want 0", busy_seen); end
    model_lat = 1;
    set_req(1, 32'd9);
    set_req(3, 32'd8);
    bus.req_valid = 4'b1010;
    wait_ready(8, n);
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rw_next_ready: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    wait_rsp(8, n);
    total++; if (n !== 2) begin bad++; $display("FAIL rw_next_latency: got %0d want 2", n); end
    total++; if (bus.rsp_valid !== 4'b0010) begin bad++; $display("FAIL rw_next_rsp_valid: got %b want 0010", bus.rsp_valid); end
    total++; if (bus.rsp_bcd !== 32'h9) begin bad++; $display("FAIL rw_next_bcd: got %h want 00000009", bus.rsp_bcd); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_timeout();
    test_done_timeout();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
